// File: rtl/b2g_pkg.sv
// b2g_pkg: shared types, width constant and Gray reference function
package b2g_pkg;
    localparam int B2G_W = 4;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;
    function automatic logic [B2G_W-1:0] gray_of(input logic [B2G_W-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/b2g_rr_sched_if.sv
// b2g_rr_sched_if: requester and response handshake bundle
interface b2g_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    import b2g_pkg::*;
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [B2G_W*N_REQ-1:0] req_bin;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [B2G_W-1:0]       rsp_gray;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;
    logic [CNT_W-1:0]       xfer_cnt;
    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_gray, rsp_id, busy, xfer_cnt
    );
    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_gray, rsp_id, busy, xfer_cnt
    );
endinterface

// File: rtl/b2g_rr_sched_bin2gray.sv
// bin2gray: 4-bit binary to Gray converter
module bin2gray
    import b2g_pkg::*;
(
    input  logic [B2G_W-1:0] bin,
    output logic [B2G_W-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/b2g_rr_sched.sv
// b2g_rr_sched: round-robin share of one bin2gray across N_REQ requesters
module b2g_rr_sched
    import b2g_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    b2g_rr_sched_if.slave bus
);
    slot_t            state, nxt;
    logic [ID_W-1:0]  rr_ptr, gnt, rsp_id;
    logic [B2G_W-1:0] bin_sel, gray_sel, rsp_gray;
    logic [CNT_W-1:0] xfer_cnt;
    logic             hit, can_accept, acc;
    int               j;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        hit = 1'b0;
        gnt = '0;
        j   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!hit && bus.req_valid[j]) begin
                hit = 1'b1;
                gnt = ID_W'(j);
            end
        end
    end

    assign can_accept    = (state == SLOT_EMPTY) || bus.rsp_ready;
    assign acc           = hit && can_accept && rst_n;
    assign bus.req_ready = acc ? (N_REQ'(1) << gnt) : '0;
    assign bin_sel       = bus.req_bin[B2G_W*gnt +: B2G_W];

    bin2gray u_b2g (.bin(bin_sel), .gray(gray_sel));

    // slot next state: fill on accept, drain when consumed without refill
    always_comb begin
        nxt = state;
        if (state == SLOT_EMPTY) nxt = acc ? SLOT_FULL : SLOT_EMPTY;
        else if (bus.rsp_ready && !acc) nxt = SLOT_EMPTY;
    end

    // slot register, result capture, pointer advance and saturating count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SLOT_EMPTY;
            rsp_gray <= '0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
            xfer_cnt <= '0;
        end else begin
            state <= nxt;
            if (acc) begin
                rsp_gray <= gray_sel;
                rsp_id   <= gnt;
                rr_ptr   <= (int'(gnt) == N_REQ-1) ? '0 : gnt + 1'b1;
                xfer_cnt <= xfer_cnt + CNT_W'(xfer_cnt != '1);
            end
        end
    end

    assign bus.rsp_valid = (state == SLOT_FULL);
    assign bus.rsp_gray  = rsp_gray;
    assign bus.rsp_id    = rsp_id;
    assign bus.xfer_cnt  = xfer_cnt;
    assign bus.busy      = bus.rsp_valid || (|bus.req_valid);
endmodule
